// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM state encoding, operation type, default width.
package mem_pkg;

    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    // Handshake: read/write are levels sampled only while the responder is idle (busy=0);
    // requests seen while busy are dropped, not queued. Completion is a one-cycle mem_ready
    // pulse; Mdatain (and mem_err when enabled) are valid while mem_ready is high.
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] MDRout;
    logic [DATA_W-1:0] Mdatain;
    logic              mem_ready;
    logic              busy;
    logic              mem_err;

    modport master (
        output read, write, addr, MDRout,
        input  Mdatain, mem_ready, busy, mem_err
    );

    modport slave (
        input  read, write, addr, MDRout,
        output Mdatain, mem_ready, busy, mem_err
    );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM; contents are never reset, only the registered read port is.
module mem_array #(
    parameter int DATA_W = 32,
    parameter int AW     = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // dout only moves on an explicit read so it can serve directly as the held read result.
    always_ff @(posedge clock) begin
        if (clear) begin
            dout <= '0;
        end else if (re) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: IDLE -> WAIT (programmable wait states) -> DONE FSM around mem_array.
// Optional bounds checking is enabled by defining MEM_BOUNDS_CHK_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic            clock,
    input  logic            clear,
    mem_responder_if.slave  bus,
    output mem_state_t      state
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    mem_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt;
    logic              access;
    logic              in_range;
    logic              ram_we;
    logic              ram_re;
    logic [AW-1:0]     ram_addr;

`ifdef MEM_BOUNDS_CHK_EN
    logic err_q;
    assign in_range    = int'(addr_q) < DEPTH;
    assign bus.mem_err = err_q;
`else
    assign in_range    = 1'b1;
    assign bus.mem_err = 1'b0;
`endif

    // clear gates the access so an abort landing on the access edge commits nothing.
    assign access   = (state == WAIT) && (cnt == '0) && !clear;
    assign ram_we   = access && (op_q == OP_WR) && in_range;
    assign ram_re   = access && (op_q == OP_RD) && in_range;
    assign ram_addr = AW'(int'(addr_q) % DEPTH);

    assign bus.busy      = (state != IDLE);
    assign bus.mem_ready = (state == DONE);

    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            op_q   <= OP_RD;
            addr_q <= '0;
            data_q <= '0;
            cnt    <= '0;
`ifdef MEM_BOUNDS_CHK_EN
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MEM_BOUNDS_CHK_EN
                    err_q <= 1'b0;
`endif
                    if (bus.read || bus.write) begin
                        op_q   <= bus.read ? OP_RD : OP_WR;
                        addr_q <= bus.addr;
                        data_q <= bus.MDRout;
                        cnt    <= CNT_W'(WAIT_STATES);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
`ifdef MEM_BOUNDS_CHK_EN
                        err_q <= !in_range;
`endif
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
`ifdef MEM_BOUNDS_CHK_EN
                    err_q <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .DEPTH  (DEPTH)
    ) u_array (
        .clock (clock),
        .clear (clear),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .din   (data_q),
        .dout  (bus.Mdatain)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_STATES=2/DEPTH=512 instance and a WAIT_STATES=0/DEPTH=256 one.
module tb_mem_responder;
  import mem_pkg::*;

  // clock / reset
  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  mem_responder_if #(.DATA_W(32), .ADDR_W(9)) ifa ();
  mem_responder_if #(.DATA_W(32), .ADDR_W(9)) ifb ();
  mem_state_t state_a;
  mem_state_t state_b;

  mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(2)) dut_a (
    .clock (clock),
    .clear (clear),
    .bus   (ifa.slave),
    .state (state_a)
  );

  mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_STATES(0)) dut_b (
    .clock (clock),
    .clear (clear),
    .bus   (ifb.slave),
    .state (state_b)
  );

  // scoreboard: expected {mem_err, Mdatain} per request
  logic [32:0] exp_qa[$];
  logic [32:0] exp_qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitors
  always @(negedge clock) begin
    if (ifa.mem_ready === 1'b1) begin
      if (exp_qa.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_ready: got mem_ready=1 expected no response");
      end else begin
        chk("a_resp", {ifa.mem_err, ifa.Mdatain}, exp_qa.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (ifb.mem_ready === 1'b1) begin
      if (exp_qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_ready: got mem_ready=1 expected no response");
      end else begin
        chk("b_resp", {ifb.mem_err, ifb.Mdatain}, exp_qb.pop_front());
      end
    end
  end

  // driver tasks
  function automatic logic get_busy(input int d);
    return (d == 0) ? ifa.busy : ifb.busy;
  endfunction

  function automatic logic get_ready(input int d);
    return (d == 0) ? ifa.mem_ready : ifb.mem_ready;
  endfunction

  task automatic drive(input int d, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] din);
    if (d == 0) begin
      ifa.read = rd; ifa.write = wr; ifa.addr = a; ifa.MDRout = din;
    end else begin
      ifb.read = rd; ifb.write = wr; ifb.addr = a; ifb.MDRout = din;
    end
  endtask

  task automatic req(input int d, input logic rd, input logic wr, input logic [8:0] a,
                     input logic [31:0] din, input logic [32:0] exp, input int exp_lat,
                     input bit inject);
    int lat;
    @(negedge clock);
    drive(d, rd, wr, a, din);
    if (d == 0) exp_qa.push_back(exp);
    else        exp_qb.push_back(exp);
    @(posedge clock); #1;
    drive(d, 1'b0, 1'b0, ~a, ~din);
    chk("busy_after_req", 33'(get_busy(d)), 33'd1);
    lat = 0;
    while (lat < 20) begin
      if (inject && lat == 0) drive(d, 1'b0, 1'b1, 9'h010, 32'hBAD0BAD0);
      @(posedge clock); #1;
      lat++;
      if (inject && lat == 1) drive(d, 1'b0, 1'b0, 9'h000, 32'h0);
      if (get_ready(d)) break;
    end
    chk("ready_latency", 33'(lat), 33'(exp_lat));
    chk("busy_with_ready", 33'(get_busy(d)), 33'd1);
    @(posedge clock); #1;
    chk("idle_after_done", 33'({get_busy(d), get_ready(d)}), 33'd0);
  endtask

  initial begin
    clear = 1'b1;
    drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 9'h0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_a_data", {ifa.mem_err, ifa.Mdatain}, 33'd0);
    chk("reset_a_flags", 33'({ifa.busy, ifa.mem_ready}), 33'd0);
    chk("reset_a_state", 33'(state_a), 33'(IDLE));
    chk("reset_b_data", {ifb.mem_err, ifb.Mdatain}, 33'd0);
    chk("reset_b_flags", 33'({ifb.busy, ifb.mem_ready}), 33'd0);
    @(negedge clock);
    clear = 1'b0;

    // WAIT_STATES=2: request at edge N, mem_ready visible after edge N+3
    req(0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, {1'b0, 32'h0},        3, 1'b0);
    req(0, 1'b1, 1'b0, 9'h005, 32'h0,        {1'b0, 32'hDEADBEEF}, 3, 1'b0);
    req(0, 1'b0, 1'b1, 9'h010, 32'h00001010, {1'b0, 32'hDEADBEEF}, 3, 1'b0);
    req(0, 1'b1, 1'b0, 9'h005, 32'h0,        {1'b0, 32'hDEADBEEF}, 3, 1'b1);
    req(0, 1'b1, 1'b0, 9'h010, 32'h0,        {1'b0, 32'h00001010}, 3, 1'b0);
    req(0, 1'b1, 1'b1, 9'h005, 32'h0BADF00D, {1'b0, 32'hDEADBEEF}, 3, 1'b0);
    req(0, 1'b1, 1'b0, 9'h010, 32'h0,        {1'b0, 32'h00001010}, 3, 1'b0);
    req(0, 1'b1, 1'b0, 9'h005, 32'h0,        {1'b0, 32'hDEADBEEF}, 3, 1'b0);
    req(0, 1'b0, 1'b1, 9'h007, 32'h11111111, {1'b0, 32'hDEADBEEF}, 3, 1'b0);

    // abort: clear sampled on the access edge N+3
    @(negedge clock);
    drive(0, 1'b0, 1'b1, 9'h007, 32'h12345678);
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    chk("abort_state", 33'(state_a), 33'(IDLE));
    chk("abort_flags", 33'({ifa.busy, ifa.mem_ready}), 33'd0);
    chk("abort_data", {ifa.mem_err, ifa.Mdatain}, 33'd0);
    @(negedge clock);
    clear = 1'b0;
    repeat (3) @(posedge clock);
    req(0, 1'b1, 1'b0, 9'h007, 32'h0, {1'b0, 32'h11111111}, 3, 1'b0);

    // reset keeps RAM contents
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    chk("clear_data", {ifa.mem_err, ifa.Mdatain}, 33'd0);
    @(negedge clock);
    clear = 1'b0;
    req(0, 1'b1, 1'b0, 9'h005, 32'h0, {1'b0, 32'hDEADBEEF}, 3, 1'b0);

    // WAIT_STATES=0, DEPTH=256
    req(1, 1'b0, 1'b1, 9'h003, 32'hA5A5A5A5, {1'b0, 32'h0},        1, 1'b0);
    req(1, 1'b1, 1'b0, 9'h003, 32'h0,        {1'b0, 32'hA5A5A5A5}, 1, 1'b0);
    req(1, 1'b0, 1'b1, 9'h0FF, 32'hCAFEF00D, {1'b0, 32'hA5A5A5A5}, 1, 1'b0);
`ifdef MEM_BOUNDS_CHK_EN
    req(1, 1'b1, 1'b0, 9'h1FF, 32'h0,        {1'b1, 32'hA5A5A5A5}, 1, 1'b0);
    req(1, 1'b0, 1'b1, 9'h1FF, 32'h0,        {1'b1, 32'hA5A5A5A5}, 1, 1'b0);
    req(1, 1'b1, 1'b0, 9'h0FF, 32'h0,        {1'b0, 32'hCAFEF00D}, 1, 1'b0);
`else
    req(1, 1'b1, 1'b0, 9'h1FF, 32'h0,        {1'b0, 32'hCAFEF00D}, 1, 1'b0);
    req(1, 1'b0, 1'b1, 9'h1FF, 32'h0,        {1'b0, 32'hCAFEF00D}, 1, 1'b0);
    req(1, 1'b1, 1'b0, 9'h0FF, 32'h0,        {1'b0, 32'h0},        1, 1'b0);
`endif
    req(1, 1'b1, 1'b0, 9'h003, 32'h0,        {1'b0, 32'hA5A5A5A5}, 1, 1'b0);

    // final report
    repeat (4) @(posedge clock);
    #1;
    chk("a_queue_drained", 33'(exp_qa.size()), 33'd0);
    chk("b_queue_drained", 33'(exp_qb.size()), 33'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
